// File: rtl/flash_prog.sv
// flash_prog: Wishbone programmer/eraser for Intel/Strata parallel NOR flash.
// Define FLASH_PROG_ERASE_EN to include the CTRL-started block erase path.
module flash_prog #(
  parameter int unsigned SETUP    = 2,
  parameter int unsigned WE_PULSE = 4,
  parameter int unsigned HOLD     = 2,
  parameter int unsigned RD_WAIT  = 6,
  parameter int unsigned TIMEOUT  = 16'hFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [2:1]  wb_adr_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [20:0] flash_addr_,
  output logic [15:0] flash_data_o_,
  input  logic [15:0] flash_data_i_,
  output logic        flash_data_oe,
  output logic        flash_we_n_,
  output logic        flash_oe_n_,
  output logic        flash_ce2_,
  output logic        flash_own_o
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_LOW, W_HOLD, P_RD, P_GAP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, sr_q, sr_d;
  logic [15:0] poll_q, poll_d, lo_q, lo_d, data_q, data_d, word_q, word_d, dat_q, dat_d;
  logic [4:0]  hi_q, hi_d;
  logic [1:0]  idx_q, idx_d;
  logic        ack_q, ack_d, done_q, done_d, err_q, err_d, tmo_q, tmo_d, ovr_q, ovr_d;
  logic        acc, wr, idle, wr_st, req_p, req_e, erase_q;
  logic [15:0] cmd, rdata;
  logic        unused_hi;

  assign unused_hi = ^flash_data_i_[15:8];
  assign acc   = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr    = acc & wb_we_i;
  assign idle  = state_q == IDLE;
  assign req_p = wr && wb_adr_i == 2'd2;

`ifdef FLASH_PROG_ERASE_EN
  assign req_e = wr && wb_adr_i == 2'd3 && wb_dat_i[0];
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) erase_q <= 1'b0;
    else if (idle && (req_p || req_e)) erase_q <= req_e;
`else
  assign req_e   = 1'b0;
  assign erase_q = 1'b0;
`endif

  // idx: 0 = setup command, 1 = confirm/data word, 2 = read-array
  assign cmd = idx_q == 2'd2 ? 16'h00FF :
               idx_q == 2'd0 ? (erase_q ? 16'h0020 : 16'h0040) :
                               (erase_q ? 16'h00D0 : word_q);
  assign rdata = wb_adr_i == 2'd0 ? lo_q :
                 wb_adr_i == 2'd1 ? {11'd0, hi_q} :
                 wb_adr_i == 2'd2 ? data_q :
                 {sr_q, 3'd0, ovr_q, tmo_q, err_q, done_q, !idle};
  assign wr_st = state_q == W_SETUP || state_q == W_LOW || state_q == W_HOLD;

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = dat_q;
  assign flash_addr_   = {hi_q, lo_q};
  assign flash_data_o_ = wr_st ? cmd : 16'h0000;
  assign flash_data_oe = wr_st;
  assign flash_we_n_   = state_q != W_LOW;
  assign flash_oe_n_   = state_q != P_RD;
  assign flash_ce2_    = !idle;
  assign flash_own_o   = !idle;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      poll_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      word_q  <= '0;
      dat_q   <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      poll_q  <= poll_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      word_q  <= word_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    sr_d    = sr_q;
    poll_d  = poll_q;
    lo_d    = wr && wb_adr_i == 2'd0 ? wb_dat_i : lo_q;
    hi_d    = wr && wb_adr_i == 2'd1 ? wb_dat_i[4:0] : hi_q;
    data_d  = req_p ? wb_dat_i : data_q;
    word_d  = word_q;
    dat_d   = acc ? rdata : dat_q;
    idx_d   = idx_q;
    ack_d   = wb_stb_i & wb_cyc_i & ~ack_q;
    // clear happens before any start/completion in the same cycle can set bits again
    {done_d, err_d, tmo_d, ovr_d} = wr && wb_adr_i == 2'd3 && wb_dat_i[1] ? 4'b0 : {done_q, err_q, tmo_q, ovr_q};
    ovr_d   = ovr_d | (!idle && (req_p || req_e));
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_p || req_e) begin
          state_d = W_SETUP;
          idx_d   = 2'd0;
          poll_d  = '0;
          word_d  = req_p ? wb_dat_i : word_q;
        end
      end
      W_SETUP: if (cnt_q == 8'(SETUP - 1)) begin
        state_d = W_LOW;
        cnt_d   = '0;
      end
      W_LOW: if (cnt_q == 8'(WE_PULSE - 1)) begin
        state_d = W_HOLD;
        cnt_d   = '0;
      end
      W_HOLD: if (cnt_q == 8'(HOLD - 1)) begin
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd0 ? W_SETUP : idx_q == 2'd1 ? P_RD : IDLE;
        done_d  = done_d | (idx_q == 2'd2);
      end
      P_RD: if (cnt_q == 8'(RD_WAIT - 1)) begin
        sr_d    = flash_data_i_[7:0];
        state_d = P_GAP;
        cnt_d   = '0;
      end
      P_GAP: begin
        cnt_d  = '0;
        poll_d = poll_q + 16'd1;
        if (sr_q[7]) begin
          err_d   = err_d | sr_q[5] | sr_q[4] | sr_q[3] | sr_q[1];
          idx_d   = 2'd2;
          state_d = W_SETUP;
        end else if (poll_d == 16'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          idx_d   = 2'd2;
          state_d = W_SETUP;
        end else state_d = P_RD;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_flash_prog.sv
// tb_flash_prog: flash_prog bench with a status-register flash model and write scoreboard.
module tb_flash_prog;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] dat_i = '0, dat_o;
  logic [1:0]  adr = '0;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0, ack;
  logic [20:0] f_addr;
  logic [15:0] f_do, f_di;
  logic        f_oe, we_n, oe_n, ce2, own;

  int total = 0, bad = 0;
  int cyc_n = 0, start_cyc = 0, first_delay = 0, first_len = 0;
  int polls = 0, poll_base = 0, addr_bad = 0, viol = 0, low_len = 0, ready_at = 0;
  logic        arm = 1'b0, prev_we = 1'b1, prev_oe = 1'b1;
  logic [7:0]  sr_val = '0;
  logic [15:0] wcap = '0, r;
  logic [20:0] exp_addr = 21'h012345;
  logic [15:0] sb[$];

  typedef struct {
    logic [1:0]  a;
    logic [15:0] w;
    logic [15:0] x;
  } vec_t;
  vec_t vt[6];

  flash_prog #(.TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_adr_i(adr), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
    .flash_addr_(f_addr), .flash_data_o_(f_do), .flash_data_i_(f_di),
    .flash_data_oe(f_oe), .flash_we_n_(we_n), .flash_oe_n_(oe_n),
    .flash_ce2_(ce2), .flash_own_o(own)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // status register becomes ready on the ready_at-th poll of the current operation
  assign f_di = {8'h5A, (ready_at != 0 && polls - poll_base >= ready_at) ? sr_val : 8'h00};

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic wb(input logic [1:0] a, input logic w, input logic [15:0] d, output logic [15:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    adr = a; we = w; dat_i = d; stb = 1'b1; cyc = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      total++;
      bad++;
      $display("FAIL wb_ack: no ack after %0d cycles", n);
    end else if (w) start_cyc = cyc_n;
    rd = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wait_idle(output logic [15:0] s);
    int n;
    n = 0;
    do begin
      wb(2'd3, 1'b0, 16'h0, s);
      n++;
    end while (s[0] && n < 200);
    if (s[0]) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: status %0h still busy", s);
    end
  endtask

  initial begin
    vt[0] = '{2'd0, 16'hFFFF, 16'hFFFF};
    vt[1] = '{2'd1, 16'hFFFF, 16'h001F};
    vt[2] = '{2'd1, 16'h00E0, 16'h0000};
    vt[3] = '{2'd0, 16'hA5A5, 16'hA5A5};
    vt[4] = '{2'd1, 16'h0001, 16'h0001};
    vt[5] = '{2'd0, 16'h2345, 16'h2345};

    fork
      forever begin
        @(negedge clk);
        if (own && f_addr !== exp_addr) addr_bad++;
        if ((!we_n && !oe_n) || (f_oe && !oe_n)) viol++;
        if (!oe_n && prev_oe) polls++;
        if (!we_n) begin
          if (prev_we) begin
            low_len = 0;
            if (arm) first_delay = cyc_n - start_cyc;
          end
          low_len++;
          wcap = f_do;
        end else if (!prev_we) begin
          if (arm) begin
            first_len = low_len;
            arm = 1'b0;
          end
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_write: got %0h want none", wcap);
          end else chk("flash_write", 64'(wcap), 64'(sb.pop_front()));
        end
        prev_we = we_n;
        prev_oe = oe_n;
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_strobes", {58'd0, we_n, oe_n, ce2, f_oe, own, ack}, 64'b110000);
    chk("rst_data", {32'd0, dat_o, f_do}, 64'd0);
    chk("rst_addr", 64'(f_addr), 64'd0);
    rst = 1'b0;
    wb(2'd3, 1'b0, 16'h0, r);
    chk("rst_status", 64'(r), 64'h0);

    for (int i = 0; i < 6; i++) begin
      wb(vt[i].a, 1'b1, vt[i].w, r);
      wb(vt[i].a, 1'b0, 16'h0, r);
      chk($sformatf("reg_vec%0d", i), 64'(r), 64'(vt[i].x));
    end

    // erase: SR ready immediately with the erase-error bit
    ready_at = 1; sr_val = 8'hA0; poll_base = polls;
`ifdef FLASH_PROG_ERASE_EN
    sb.push_back(16'h0020); sb.push_back(16'h00D0); sb.push_back(16'h00FF);
`endif
    wb(2'd3, 1'b1, 16'h0001, r);
    wait_idle(r);
`ifdef FLASH_PROG_ERASE_EN
    chk("erase_status", 64'(r), 64'hA006);
    chk("erase_polls", 64'(polls - poll_base), 64'd1);
`else
    chk("erase_status", 64'(r), 64'h0000);
    chk("erase_polls", 64'(polls - poll_base), 64'd0);
`endif
    chk("erase_sb_empty", 64'(sb.size()), 64'd0);
    wb(2'd3, 1'b1, 16'h0002, r);
    wb(2'd3, 1'b0, 16'h0, r);
`ifdef FLASH_PROG_ERASE_EN
    chk("erase_clear", 64'(r), 64'hA000);
`else
    chk("erase_clear", 64'(r), 64'h0000);
`endif

    // program: SR ready on the third poll
    ready_at = 3; sr_val = 8'h80; poll_base = polls; arm = 1'b1;
    sb.push_back(16'h0040); sb.push_back(16'hBEEF); sb.push_back(16'h00FF);
    wb(2'd2, 1'b1, 16'hBEEF, r);
    wait_idle(r);
    chk("prog_status", 64'(r), 64'h8002);
    chk("prog_polls", 64'(polls - poll_base), 64'd3);
    chk("prog_we_delay", 64'(first_delay), 64'd2);
    chk("prog_we_len", 64'(first_len), 64'd4);
    chk("prog_sb_empty", 64'(sb.size()), 64'd0);
    wb(2'd3, 1'b1, 16'h0002, r);
    wb(2'd3, 1'b0, 16'h0, r);
    chk("prog_clear", 64'(r), 64'h8000);

    // timeout: SR never ready
    ready_at = 0; sr_val = 8'h00; poll_base = polls;
    sb.push_back(16'h0040); sb.push_back(16'h5555); sb.push_back(16'h00FF);
    wb(2'd2, 1'b1, 16'h5555, r);
    wait_idle(r);
    chk("tmo_status", 64'(r), 64'h000A);
    chk("tmo_polls", 64'(polls - poll_base), 64'd4);
    chk("tmo_sb_empty", 64'(sb.size()), 64'd0);

    // clear and start erase in one CTRL write
    ready_at = 1; sr_val = 8'h80; poll_base = polls;
`ifdef FLASH_PROG_ERASE_EN
    sb.push_back(16'h0020); sb.push_back(16'h00D0); sb.push_back(16'h00FF);
`endif
    wb(2'd3, 1'b1, 16'h0003, r);
    wb(2'd3, 1'b0, 16'h0, r);
`ifdef FLASH_PROG_ERASE_EN
    chk("clr_start_busy", 64'(r), 64'h0001);
    wait_idle(r);
    chk("clr_start_final", 64'(r), 64'h8002);
`else
    chk("clr_start_busy", 64'(r), 64'h0000);
    wait_idle(r);
    chk("clr_start_final", 64'(r), 64'h0000);
`endif
    chk("clr_start_sb_empty", 64'(sb.size()), 64'd0);
    wb(2'd3, 1'b1, 16'h0002, r);

    // overrun: DATA write while busy
    ready_at = 3; sr_val = 8'h80; poll_base = polls;
    sb.push_back(16'h0040); sb.push_back(16'h7777); sb.push_back(16'h00FF);
    wb(2'd2, 1'b1, 16'h7777, r);
    wb(2'd2, 1'b1, 16'h1111, r);
    wait_idle(r);
    chk("ovr_status", 64'(r), 64'h8012);
    chk("ovr_polls", 64'(polls - poll_base), 64'd3);
    chk("ovr_sb_empty", 64'(sb.size()), 64'd0);
    wb(2'd2, 1'b0, 16'h0, r);
    chk("ovr_data", 64'(r), 64'h1111);
    wb(2'd3, 1'b1, 16'h0002, r);
    wb(2'd3, 1'b0, 16'h0, r);
    chk("ovr_clear", 64'(r), 64'h8000);

    // asynchronous reset during the write pulse
    sb.push_back(16'h0040);
    wb(2'd2, 1'b1, 16'h2222, r);
    for (int n = 0; n < 50 && we_n; n++) @(negedge clk);
    chk("rst_mid_reached_low", 64'(we_n), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_async", {60'd0, we_n, own, ce2, f_oe}, 64'b1000);
    @(negedge clk);
    rst = 1'b0;
    wb(2'd3, 1'b0, 16'h0, r);
    chk("rst_mid_status", 64'(r), 64'h0000);
    chk("rst_mid_sb_empty", 64'(sb.size()), 64'd0);

    repeat (4) @(negedge clk);
    chk("strobe_overlap", 64'(viol), 64'd0);
    chk("addr_stable", 64'(addr_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_prog.md
# flash_prog

Wishbone slave that programs and erases the board's parallel NOR flash (Intel/Strata command set), complementing the read-only flash controller: it drives the flash write strobe, data bus and command sequences, and polls the status register until the device finishes. It sits on the same flash pads as the read controller; the top level gives it the pads while `flash_own_o` is high. Software loads an address and data word, then polls a status register.

## Interface
Parameters:
- `SETUP`, 2: cycles address/data/CE are valid before `flash_we_n_` falls (≥1).
- `WE_PULSE`, 4: cycles `flash_we_n_` is held low (≥1).
- `HOLD`, 2: cycles address/data are held after `flash_we_n_` rises (≥1).
- `RD_WAIT`, 6: cycles `flash_oe_n_` is low per status read (≥1).
- `TIMEOUT`, 16'hFFFF: maximum status polls before giving up.

Ports (one clock; reset is asynchronous and active-high):
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: asynchronous active-high reset.
- `wb_dat_i` in 16: write data.
- `wb_dat_o` out 16: read data.
- `wb_adr_i` in [2:1]: register select.
- `wb_we_i`, `wb_stb_i`, `wb_cyc_i` in 1: Wishbone controls.
- `wb_ack_o` out 1: acknowledge.
- `flash_addr_` out 21: word address.
- `flash_data_o_` out 16: data driven to the flash.
- `flash_data_i_` in 16: data from the flash.
- `flash_data_oe` out 1: pad tristate enable for `flash_data_o_`.
- `flash_we_n_`, `flash_oe_n_` out 1: active-low strobes.
- `flash_ce2_` out 1: active-high chip enable.
- `flash_own_o` out 1: block owns the flash pads.

## Operation
- Registers (`wb_adr_i`):
  - 0: ADDR_LO, address [15:0].
  - 1: ADDR_HI, address [20:16] in bits [4:0]; reads return zeros above bit 4.
  - 2: DATA, read/write. A write while idle starts PROGRAM.
  - 3: CTRL/STATUS.
- STATUS read: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 TMO, bit4 OVR, bits[15:8] last SR.
- CTRL write: bit0=1 starts ERASE (when idle); bit1=1 clears DONE/ERR/TMO/OVR.
- Any start request while BUSY is ignored and sets OVR. DATA is still updated.
- Command lists:
  - PROGRAM: 0x0040, then DATA.
  - ERASE: 0x0020, then 0x00D0.
  - Each list is followed by polling, then 0x00FF (read array).
- FSM states: IDLE → W_SETUP → W_LOW → W_HOLD (repeat per command word) → P_RD → P_GAP → (P_RD, or W_SETUP for 0x00FF) → IDLE.
  - W_SETUP: `flash_ce2_`=1, `flash_data_oe`=1, `flash_data_o_`=current word.
  - W_LOW: `flash_we_n_`=0.
  - W_HOLD: `flash_we_n_`=1, data still driven.
  - P_RD: `flash_oe_n_`=0, `flash_data_oe`=0. SR is sampled from `flash_data_i_[7:0]` on the last cycle.
  - P_GAP: 1 cycle with both strobes high.
- Poll exit:
  - SR[7]=1: go to read-array write. ERR = |{SR[5],SR[4],SR[3],SR[1]}.
  - SR[7]=0: increment 16-bit poll count. When the count reaches TIMEOUT, set TMO and go to read-array write.
- DONE is set on return to IDLE.
- `flash_addr_` = {ADDR_HI, ADDR_LO} for every command and poll.
- `flash_own_o` is high in every state except IDLE.

## Timing
- `wb_ack_o` rises one cycle after `wb_stb_i & wb_cyc_i`, is high for one cycle, and is never high on consecutive cycles (`ack <= op & ~ack`). Read data is valid with ack.
- The FSM leaves IDLE on the same edge that asserts ack for a start write.
- `flash_we_n_` falls exactly SETUP cycles after that edge.
- One command write lasts SETUP+WE_PULSE+HOLD cycles; back-to-back command words re-enter W_SETUP.
- One poll lasts RD_WAIT+1 cycles.
- Reset values, applied asynchronously on `wb_rst_i`, including mid-operation:
  - Outputs: `wb_ack_o`=0, `wb_dat_o`=0, `flash_we_n_`=1, `flash_oe_n_`=1, `flash_ce2_`=0, `flash_data_oe`=0, `flash_data_o_`=0, `flash_addr_`=0, `flash_own_o`=0.
  - State and registers: FSM IDLE, all registers and status bits 0.
- `flash_we_n_` and `flash_oe_n_` are never low in the same cycle.
- `flash_data_oe` is never 1 while `flash_oe_n_`=0.
- A CTRL write with bit1=1 and bit0=1 while idle clears the sticky bits, then starts the erase (DONE reads 0 after the ack).

## Configuration
- `FLASH_PROG_ERASE_EN` defined: ERASE command path present.
- Undefined: CTRL bit0 is ignored (no OVR, no start), no erase logic is generated, and PROGRAM is unchanged.

## Test plan
- Program: ADDR_HI=0x01, ADDR_LO=0x2345, DATA=0xBEEF; model SR=0x80 on the 3rd poll.
  - `flash_addr_`=0x012345 on all cycles.
  - Writes occur in order 0x0040, 0xBEEF, 0x00FF.
  - Exactly 3 `flash_oe_n_` pulses.
  - STATUS=0x8002.
- Erase: CTRL=0x0001; model SR=0xA0 (SR5) immediately.
  - Writes occur in order 0x0020, 0x00D0, 0x00FF.
  - STATUS=0xA006.
  - With the macro undefined: no flash activity and STATUS=0x0000.
- Timeout: TIMEOUT=4, model SR=0x00 forever.
  - Exactly 4 polls, then 0x00FF.
  - STATUS bits TMO=1, DONE=1.
- Overrun: write DATA=0x1111 during an active program.
  - OVR=1, no extra flash write, DATA reads 0x1111.
  - CTRL=0x0002 then clears OVR/DONE.
- Reset mid-W_LOW: assert `wb_rst_i` asynchronously.
  - `flash_we_n_`=1 and `flash_own_o`=0 before the next clock edge.
  - After release, STATUS=0x0000.
- Strobe timing with defaults: `flash_we_n_` is low for exactly 4 cycles, falling 2 cycles after the start ack edge.
  - Assertion: WE/OE never overlap and `flash_data_oe` is never 1 while `flash_oe_n_`=0.
